// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter -- iterative multiply/divide unit (EX stage)
//
// Runs MULT/MULTU as a radix-2 shift-add and DIV/DIVU as a restoring divide.
// Each op takes one bit per cycle over XLEN cycles plus one finalisation
// cycle. The result lands in the architectural HI/LO registers. busy_o
// stalls the front of the pipe while an op is in flight. done_o pulses for
// one cycle when an op has written HI/LO.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous reset, active high
//   start_i        launch an op (honoured only in IDLE and without flush)
//   op_i[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a_i        multiplicand / dividend (rs)
//   src_b_i        multiplier / divisor (rt)
//   mthi_i/mtlo_i  write wdata_i to HI/LO (IDLE, no start, no flush)
//   wdata_i        MTHI/MTLO data
//   flush_i        cancels an in-flight op; HI/LO keep their old values
//   busy_o         op in flight
//   done_o         one-cycle pulse after HI/LO were written by an op
//   hi_o, lo_o     architectural HI and LO
// -----------------------------------------------------------------------------
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            mthi_i,
    input  logic            mtlo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              is_div_q, is_div_d;
    logic              is_sgn_q, is_sgn_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              divz_q,   divz_d;
    logic [XLEN-1:0]   src_a_q,  src_a_d;   // original dividend, for divide-by-zero HI
    logic [XLEN-1:0]   opnd_q,   opnd_d;    // |multiplicand| or |divisor|
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic [XLEN-1:0]   hi_q,     hi_d;
    logic [XLEN-1:0]   lo_q,     lo_d;
    logic              done_q,   done_d;

    // ---------------------------------------------------------------------
    // Launch-time operand conditioning
    // ---------------------------------------------------------------------
    logic            l_div, l_sgn, l_sa, l_sb;
    logic [XLEN-1:0] l_mag_a, l_mag_b;

    always_comb begin
        l_div   = op_i[1];
        l_sgn   = ~op_i[0];
        l_sa    = l_sgn & src_a_i[XLEN-1];
        l_sb    = l_sgn & src_b_i[XLEN-1];
        l_mag_a = l_sa ? (~src_a_i + 1'b1) : src_a_i;
        l_mag_b = l_sb ? (~src_b_i + 1'b1) : src_b_i;
    end

    // ---------------------------------------------------------------------
    // One iteration step
    // ---------------------------------------------------------------------
    // Multiply: acc = {partial product, remaining multiplier bits}. The
    // upper half accumulates and the whole register shifts right, so after
    // XLEN steps the multiplier bits are gone and acc holds the product.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    // Divide: acc = {partial remainder, dividend bits / quotient bits}.
    // Quotient bits enter at the bottom as dividend bits leave at the top.
    logic [XLEN:0]     div_rem_sh;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next   = {mul_sum, acc_q[XLEN-1:1]};

        div_rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff   = div_rem_sh - {1'b0, opnd_q};
        div_ge     = ~div_diff[XLEN];
        div_next   = {(div_ge ? div_diff[XLEN-1:0] : div_rem_sh[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};
    end

    // ---------------------------------------------------------------------
    // Final sign correction
    // ---------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   res_hi, res_lo;

    always_comb begin
        prod_fix = (is_sgn_q & (sign_a_q ^ sign_b_q)) ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = (is_sgn_q & (sign_a_q ^ sign_b_q)) ? (~acc_q[XLEN-1:0] + 1'b1)
                                                      : acc_q[XLEN-1:0];
        // Remainder follows the sign of the dividend.
        rem_fix  = (is_sgn_q & sign_a_q) ? (~acc_q[2*XLEN-1:XLEN] + 1'b1)
                                         : acc_q[2*XLEN-1:XLEN];
        if (!is_div_q) begin
            res_hi = prod_fix[2*XLEN-1:XLEN];
            res_lo = prod_fix[XLEN-1:0];
        end else if (divz_q) begin
            // Divide by zero: defined result, no trap.
            res_hi = src_a_q;
            res_lo = '1;
        end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        is_sgn_d = is_sgn_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        divz_d   = divz_q;
        src_a_d  = src_a_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = l_div;
                    is_sgn_d = l_sgn;
                    sign_a_d = l_sa;
                    sign_b_d = l_sb;
                    divz_d   = (src_b_i == '0);
                    src_a_d  = src_a_i;
                    // Multiply walks the multiplier; divide walks the dividend.
                    opnd_d   = l_div ? l_mag_b : l_mag_a;
                    acc_d    = {{XLEN{1'b0}}, (l_div ? l_mag_a : l_mag_b)};
                end else if (!start_i && !flush_i) begin
                    if (mthi_i) hi_d = wdata_i;
                    if (mtlo_i) lo_d = wdata_i;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            is_sgn_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            divz_q   <= 1'b0;
            src_a_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            is_sgn_q <= is_sgn_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            divz_q   <= divz_d;
            src_a_q  <= src_a_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // busy decodes the state register directly, so it is glitch-free and
    // drops together with the done pulse.
    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        mthi, mtlo, flush;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] exp_q[$];      // {hi, lo} expected per completing op
    logic [31:0] model_hi, model_lo;

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .src_a_i (src_a),
        .src_b_i (src_b),
        .mthi_i  (mthi),
        .mtlo_i  (mtlo),
        .wdata_i (wdata),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Reference model: plain 64-bit arithmetic. Returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = 64'(sa * sb); return p; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;  // truncating; remainder follows dividend
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", hi, lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hi", {32'b0, hi}, {32'b0, e[63:32]});
                check("result_lo", {32'b0, lo}, {32'b0, e[31:0]});
            end
        end
    end

    // Launch an op and follow it to completion. poke>=0 drives a spurious
    // start+mthi on that busy cycle; mt_with_start raises mthi/mtlo with start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input bit mt_with_start);
        logic [63:0] r;
        int n;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        if (mt_with_start) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF; end
        r = model(o, a, b);
        exp_q.push_back(r);
        model_hi = r[63:32];
        model_lo = r[31:0];
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("busy_rise", {63'b0, busy}, 64'd1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == poke) begin
                start = 1'b1; op = ~o; src_a = $urandom; src_b = $urandom;
                mthi = 1'b1; wdata = $urandom;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0;
        check("busy_cycles", 64'(n), 64'd33);
        check("done_at_busy_fall", {63'b0, done}, 64'd1);
    endtask

    task automatic write_mt(input logic h, input logic l, input logic [31:0] d);
        @(negedge clk);
        mthi = h; mtlo = l; wdata = d;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        if (h) model_hi = d;
        if (l) model_lo = d;
        check("mt_hi", {32'b0, hi}, {32'b0, model_hi});
        check("mt_lo", {32'b0, lo}, {32'b0, model_lo});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        wdata = '0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        model_hi = '0; model_lo = '0;
        #13;
        check("reset_hi",   {32'b0, hi}, 64'd0);
        check("reset_lo",   {32'b0, lo}, 64'd0);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        check("multu_max_hi", {32'b0, hi}, 64'hFFFF_FFFE);
        check("multu_max_lo", {32'b0, lo}, 64'h0000_0001);
        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, -1, 1'b0);
        check("mult_neg_lo", {32'b0, lo}, 64'hFFFF_FFFA);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0);
        check("div_neg_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        check("div_neg_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        run_op(2'b11, 32'd7, 32'd2, -1, 1'b0);
        run_op(2'b11, 32'h1234_5678, 32'h0, -1, 1'b0);
        check("divz_hi", {32'b0, hi}, 64'h1234_5678);
        run_op(2'b10, 32'hFFFF_FFF0, 32'h0, -1, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        check("div_ovf_lo", {32'b0, lo}, 64'h8000_0000);
        check("div_ovf_hi", {32'b0, hi}, 64'h0);

        // MTHI/MTLO, separately and together
        write_mt(1'b1, 1'b0, 32'h1111_2222);
        write_mt(1'b0, 1'b1, 32'h3333_4444);
        write_mt(1'b1, 1'b1, 32'h5555_6666);

        // Flush mid-op: no done, HI/LO preserved
        write_mt(1'b1, 1'b0, 32'hAAAA_0000);
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'b0, busy}, 64'd0);
        check("flush_done", {63'b0, done}, 64'd0);
        check("flush_hi", {32'b0, hi}, 64'hAAAA_0000);
        check("flush_lo", {32'b0, lo}, {32'b0, model_lo});
        repeat (2) @(negedge clk);
        run_op(2'b00, 32'd3, 32'd4, -1, 1'b0);

        // start together with flush in IDLE is ignored
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", {63'b0, busy}, 64'd0);

        // start/mthi while busy ignored; mthi alongside start ignored
        run_op(2'b11, 32'd1000, 32'd7, 5, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, 1'b1);
        repeat (3) @(negedge clk);
        check("no_extra_done_q", 64'(exp_q.size()), 64'd0);
        check("hold_hi", {32'b0, hi}, {32'b0, model_hi});

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'hFFFF_0000; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {63'b0, busy}, 64'd0);
        check("arst_hi", {32'b0, hi}, 64'd0);
        check("arst_lo", {32'b0, lo}, 64'd0);
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'h0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) ra = 32'($urandom_range(0, 100));
            run_op(ro, ra, rb, ($urandom_range(0, 3) == 0) ? 7 : -1, 1'b0);
            if ($urandom_range(0, 4) == 0)
                write_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
